seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed BCD to 7-segment display driver for the microwave front panel. It latches NUM_DIGITS packed BCD digits and scans them one at a time onto a shared segment bus with per-digit enables. It adds leading-zero blanking, whole-display blinking (for the "done" and "set time" states) and invalid-code blanking. It sits between the timer/countdown logic and the board display pins.

---
 rtl/seg7_scan_driver_if.sv | 38 +++
 rtl/seg7_scan_driver.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display-side bundle between the countdown logic and
// the seg7_scan_driver block. The master (countdown logic) supplies digits
// and display modes; the slave (scan driver) returns the panel pin values.
// Define SEG7_DP_EN to add the per-digit decimal point lines.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic                    load;
    logic                    blank_lz;
    logic                    blink_en;
    logic [6:0]              segs;
    logic [NUM_DIGITS-1:0]   digit_sel;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    seg_dp;

    modport master (
        output bcd_in, load, blank_lz, blink_en, dp_in,
        input  segs, digit_sel, seg_dp
    );

    modport slave (
        input  bcd_in, load, blank_lz, blink_en, dp_in,
        output segs, digit_sel, seg_dp
    );
`else
    modport master (
        output bcd_in, load, blank_lz, blink_en,
        input  segs, digit_sel
    );

    modport slave (
        input  bcd_in, load, blank_lz, blink_en,
        output segs, digit_sel
    );
`endif
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed BCD to 7-segment driver for the
// microwave front panel. Latches NUM_DIGITS packed BCD digits on load and
// scans them onto a shared active-low segment bus with active-low digit
// enables. Adds leading-zero blanking, whole-display blinking and blanking
// of non-BCD codes. Optional macro SEG7_DP_EN adds the decimal point.
// The interface instance must use the same NUM_DIGITS as this module.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    seg7_scan_driver_if.slave bus
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int BLINK_W = (BLINK_DIV > 1)  ? $clog2(BLINK_DIV)  : 1;

    logic [4*NUM_DIGITS-1:0] shadow;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    blink_phase;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_code;
    logic                    blink_blank;
    logic [6:0]              next_segs;
    logic [NUM_DIGITS-1:0]   next_sel;

    // Active-low segment pattern for one BCD code; non-BCD codes go dark.
    function automatic logic [6:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0001100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Capture the displayed digits; the scan only ever reads this copy.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block order.
        if (reset) begin
            shadow <= '0;
        end else if (bus.load) begin
            shadow <= bus.bcd_in;
        end
    end

    // Dwell counter and digit index: advance one digit every SCAN_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 1'b1;
            end
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink half-period timer; held cleared while blinking is off.
    always_ff @(posedge clk) begin
        if (reset || !bus.blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Mark digits that sit inside a run of zeros reaching the top digit;
    // digit 0 is never marked so an all-zero value still shows one 0.
    always_comb begin
        logic zero_above;
        // NOTE: every combinational output gets a default before any
        // conditional update, so no path can infer a latch.
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above  = zero_above & (shadow[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_above;
        end
    end

    // Pick the next segment pattern and digit enable for the current index.
    always_comb begin
        cur_code    = shadow[{digit_idx, 2'b00} +: 4];
        blink_blank = bus.blink_en & blink_phase;
        next_sel    = '1;
        next_sel[digit_idx] = 1'b0;
        if (blink_blank) begin
            next_segs = 7'b1111111;
        end else if (bus.blank_lz && lz_blank[digit_idx]) begin
            next_segs = 7'b1111111;
        end else begin
            next_segs = decode(cur_code);
        end
    end

    // Registered panel outputs: all digits dark while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.segs      <= 7'b1111111;
            bus.digit_sel <= '1;
        end else begin
            bus.segs      <= next_segs;
            bus.digit_sel <= next_sel;
        end
    end

`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0] dp_shadow;

    // Decimal point capture and output; ignores leading-zero blanking.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_shadow  <= '0;
            bus.seg_dp <= 1'b1;
        end else begin
            if (bus.load) begin
                dp_shadow <= bus.dp_in;
            end
            bus.seg_dp <= blink_blank ? 1'b1 : ~dp_shadow[digit_idx];
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed plus randomized checks of seg7_scan_driver
// (NUM_DIGITS=3, SCAN_DIV=4, BLINK_DIV=16) against an edge-count model.
module tb_seg7_scan_driver;

    localparam int ND        = 3;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: displayed value, edges since reset, consecutive blink edges.
    logic [11:0] m_shadow;
    int          m_scan;
    int          m_blink;
    int          m_idx;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] code);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};
        if (code > 4'd9) return 7'b1111111;
        return tbl[code];
    endfunction

    // One clock edge: predict from the spec rules, then compare just after.
    task automatic tick();
        logic [6:0]  es;
        logic [2:0]  ed;
        logic [11:0] upper;
        logic        ph;
        @(posedge clk);
        if (reset) begin
            es       = 7'b1111111;
            ed       = 3'b111;
            m_shadow = '0;
            m_scan   = 0;
            m_blink  = 0;
        end else begin
            m_idx = (m_scan / SCAN_DIV) % ND;
            ph    = ((m_blink / BLINK_DIV) % 2) == 1;
            ed    = ~(3'b001 << m_idx);
            upper = m_shadow >> (4 * m_idx);
            if (bus.blink_en && ph)
                es = 7'b1111111;
            else if (bus.blank_lz && m_idx != 0 && upper == 12'd0)
                es = 7'b1111111;
            else
                es = seg_ref(upper[3:0]);
            m_scan++;
            m_blink = bus.blink_en ? m_blink + 1 : 0;
            if (bus.load) m_shadow = bus.bcd_in;
        end
        #1;
        check("segs", {25'd0, bus.segs}, {25'd0, es});
        check("digit_sel", {29'd0, bus.digit_sel}, {29'd0, ed});
    endtask

    task automatic load_value(input logic [11:0] v);
        bus.bcd_in = v;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int blanks;
        reset        = 1'b1;
        bus.bcd_in   = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_en = 1'b0;
`ifdef SEG7_DP_EN
        bus.dp_in    = '0;
`endif
        m_shadow = '0;
        m_scan   = 0;
        m_blink  = 0;
        m_idx    = 0;
        #2;

        // Reset held for three edges, then release.
        run(3);
        check("rst_segs", {25'd0, bus.segs}, 32'h7f);
        check("rst_sel", {29'd0, bus.digit_sel}, 32'h7);
        reset = 1'b0;
        tick();
        check("rel_sel", {29'd0, bus.digit_sel}, 32'h6);
        check("rel_segs", {25'd0, bus.segs}, 32'h01);

        // Plain scan of 130.
        load_value(12'h130);
        run(26);

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        load_value(12'h005);
        run(14);
        load_value(12'h000);
        run(14);

        // Invalid code in the middle digit.
        load_value(12'h0A7);
        run(14);

        // Blink over 130 for two full periods, counting dark edges.
        bus.blank_lz = 1'b0;
        load_value(12'h130);
        run(2);
        bus.blink_en = 1'b1;
        blanks = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (bus.segs == 7'b1111111) blanks++;
        end
        check("blink_dark_edges", blanks, 32);
        bus.blink_en = 1'b0;
        tick();
        check("blink_off_lit", {31'd0, bus.segs != 7'b1111111}, 32'd1);
        run(4);

        // Reset while digit 1 is selected, with load also asserted.
        for (int i = 0; i < 16; i++) begin
            if (((m_scan / SCAN_DIV) % ND) == 1) break;
            tick();
        end
        reset      = 1'b1;
        bus.load   = 1'b1;
        bus.bcd_in = 12'h999;
        tick();
        reset    = 1'b0;
        bus.load = 1'b0;
        tick();
        check("rst_mid_sel", {29'd0, bus.digit_sel}, 32'h6);
        check("rst_mid_segs", {25'd0, bus.segs}, 32'h01);
        run(12);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.load = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0)
                bus.bcd_in = 12'($urandom_range(0, 15) << 8) | 12'($urandom_range(0, 1) << 4)
                             | 12'($urandom_range(0, 15));
            else
                bus.bcd_in = 12'($urandom);
            if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 59) == 0) bus.blink_en = ~bus.blink_en;
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
